// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between NUM_REQ writeback sources.
// Define REGFILE_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NUM_REQ-1:0]      i_req_valid,
    input  logic [5*NUM_REQ-1:0]    i_req_sel,
    input  logic [32*NUM_REQ-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]      o_req_ready,
    output logic                    o_write_en,
    output logic [4:0]              o_selectW,
    output logic [31:0]             o_portW,
    output logic [IDX_W-1:0]        o_grant_id
);

    logic [4:0]         sel_a  [NUM_REQ];
    logic [31:0]        data_a [NUM_REQ];
    logic [IDX_W-1:0]   base_s;
    logic               found_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic [4:0]         grant_sel_s;
    logic [31:0]        grant_data_s;

    logic               write_en_q, write_en_d;
    logic [4:0]         sel_q, sel_d;
    logic [31:0]        data_q, data_d;
    logic [IDX_W-1:0]   grant_id_q, grant_id_d;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign sel_a[g]  = i_req_sel[5*g +: 5];
        assign data_a[g] = i_req_data[32*g +: 32];
    end

`ifdef REGFILE_ARB_FIXED_PRIO_EN
    assign base_s = '0;
`else
    logic [IDX_W-1:0] ptr_q, ptr_d;

    assign base_s = ptr_q;

    // Pointer moves just past the requester that transferred; holds otherwise.
    always_comb begin
        ptr_d = ptr_q;
        if (found_s) begin
            ptr_d = (grant_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + IDX_W'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Scan from the base index upward with wrap; first valid requester wins. No grant under reset.
    always_comb begin
        int               raw;
        logic [IDX_W-1:0] scan_idx;
        logic             hit;
        raw          = 0;
        scan_idx     = '0;
        hit          = 1'b0;
        found_s      = 1'b0;
        grant_idx_s  = '0;
        grant_sel_s  = 5'd0;
        grant_data_s = 32'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            raw          = int'(base_s) + i;
            scan_idx     = (raw >= NUM_REQ) ? IDX_W'(raw - NUM_REQ) : IDX_W'(raw);
            hit          = !found_s && i_req_valid[scan_idx] && !i_reset;
            found_s      = found_s | hit;
            grant_idx_s  = hit ? scan_idx          : grant_idx_s;
            grant_sel_s  = hit ? sel_a[scan_idx]   : grant_sel_s;
            grant_data_s = hit ? data_a[scan_idx]  : grant_data_s;
        end
    end

    assign o_req_ready = found_s ? (NUM_REQ'(1) << grant_idx_s) : '0;

    // Output stage next state: a register-0 request is consumed but never enables a write.
    always_comb begin
        write_en_d = found_s && (grant_sel_s != 5'd0);
        sel_d      = found_s ? grant_sel_s  : sel_q;
        data_d     = found_s ? grant_data_s : data_q;
        grant_id_d = found_s ? grant_idx_s  : grant_id_q;
    end

    // Registered write port.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            write_en_q <= 1'b0;
            sel_q      <= 5'd0;
            data_q     <= 32'd0;
            grant_id_q <= '0;
        end else begin
            write_en_q <= write_en_d;
            sel_q      <= sel_d;
            data_q     <= data_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign o_write_en = write_en_q;
    assign o_selectW  = sel_q;
    assign o_portW    = data_q;
    assign o_grant_id = grant_id_q;

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between NUM_REQ writeback sources (ALU, load unit, multiply/divide, ...). Each source presents a valid/ready write request; the block grants at most one per cycle by round-robin and drives the register file write port (write enable, write select, write data) from a registered output stage. It sits between the execute/memory writeback paths and the register file.

## Interface
Parameters:
- NUM_REQ, 3: number of requesters; legal range 2..8.
- IDX_W, $clog2(NUM_REQ): width of the grant index.

Ports:
- i_clk  input  1  sole clock; all state updates on posedge.
- i_reset  input  1  reset, synchronous and active-high.
- i_req_valid  input  NUM_REQ  per-requester write request.
- i_req_sel  input  5*NUM_REQ  destination register, requester k at bits [5k+4:5k].
- i_req_data  input  32*NUM_REQ  write data, requester k at bits [32k+31:32k].
- o_req_ready  output  NUM_REQ  one-hot (or zero) grant; combinational from i_req_valid and the priority pointer.
- o_write_en  output  1  register file write enable.
- o_selectW  output  5  register file write select.
- o_portW  output  32  register file write data.
- o_grant_id  output  IDX_W  index of the requester whose write is on the port (valid when o_write_en=1).

## Operation
- A transfer for requester k happens in a cycle where i_req_valid[k] && o_req_ready[k].
- Requester rules: once valid is raised, sel and data stay stable and valid stays high until the transfer. The bench checks this rule; the block does not.
- Arbitration: each cycle, the first valid requester scanning from ptr upward (wrapping at NUM_REQ-1 → 0) is granted. o_req_ready has at most one bit set. It is all zero when no requester is valid.
- Pointer: after a transfer by k, ptr ← (k+1) mod NUM_REQ. With no transfer, ptr holds. Reset value is ptr=0.
- Output stage, registered on each transfer by k:
  - o_selectW ← sel_k
  - o_portW ← data_k
  - o_grant_id ← k
  - o_write_en ← (sel_k != 0)
- With no transfer, o_write_en ← 0; o_selectW, o_portW and o_grant_id hold.
- Register 0 handling: a request with sel=0 is still granted and consumed, and it advances ptr. It never asserts o_write_en, because writes to register 0 are discarded.
- Reset values: ptr=0, o_write_en=0, o_selectW=0, o_portW=0, o_grant_id=0. o_req_ready is all zero while i_reset=1.

## Timing
- Grant is combinational in the request cycle (cycle N).
- The write appears on the port in cycle N+1, and the register file captures it at the end of N+1. Latency is one cycle; throughput is one write per cycle.
- Back-to-back grants to different requesters in consecutive cycles are legal.
- The same requester holding valid is re-granted only after all other valid requesters have been served.
- Reset asserted mid-operation: no grant in that cycle. Any write staged from the previous cycle is dropped, and o_write_en=0 in the cycle after reset is sampled.
- Pending requests are not remembered across reset. Requesters must re-present them.
- Simultaneous requests to the same destination register from two sources are serialized in grant order. The later grant's data is the final value.

## Configuration
- Macro: REGFILE_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index valid requester always wins, ptr is not implemented, and results are independent of history.
- Undefined (default): round-robin as described above.

## Test plan
- After reset, no requests for 4 cycles → o_write_en=0, o_req_ready=0, o_selectW=0, o_portW=0 throughout.
- Requester 1 only: valid=1, sel=5, data=32'hDEADBEEF in cycle N → o_req_ready=3'b010 in N; in N+1 o_write_en=1, o_selectW=5, o_portW=32'hDEADBEEF, o_grant_id=1; o_write_en=0 in N+2.
- All three requesters held valid (sel 1/2/3, data 32'h11/22/33) from reset → grants 0,1,2,0,1,2 on consecutive cycles; port shows sel 1,2,3,1,... one cycle later. With REGFILE_ARB_FIXED_PRIO_EN the grant is 0 on every cycle.
- Requester 2 with sel=0, data=32'hFFFFFFFF → o_req_ready[2]=1 and the request is consumed; o_write_en stays 0 the next cycle; the next contending grant goes to requester 0.
- Requester 0 transfers (sel=7) in cycle N and i_reset=1 in N+1 → o_write_en=0 in N+2; ptr=0 afterwards (requesters 0 and 1 both valid → 0 granted first).
- Requesters 0 and 2 both target sel=9, data 32'hA and 32'hB, from ptr=0 → writes 32'hA then 32'hB on consecutive cycles; the final register value is 32'hB.
